// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM generator / capture pair.
package pwm_pkg;

    localparam int CNT_W_DEFAULT = 16;
    localparam int PRESCALE_MAX  = 15;
    // The prescaler counter must hold 2^PRESCALE_MAX - 1.
    localparam int PRESC_W       = PRESCALE_MAX;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_MEAS_HIGH = 2'd2,
        ST_MEAS_LOW  = 2'd3
    } cap_state_e;

    function automatic logic [3:0] clamp_prescale(input logic [7:0] prescale);
        if (prescale > 8'(PRESCALE_MAX)) begin
            return 4'(PRESCALE_MAX);
        end
        return prescale[3:0];
    endfunction

endpackage

// File: rtl/pwm_in_sync.sv
// Brings the asynchronous PWM pin into the clk domain and produces
// single-cycle rise/fall pulses on the (optionally inverted) level.
module pwm_in_sync (
    input  logic clk,
    input  logic rst,
    input  logic polarity_i,
    input  logic pwm_i,
    output logic rise_o,
    output logic fall_o
);

    // [0] metastable stage, [1] synchronized level, [2] previous level.
    logic [2:0] sync_q;
    logic [2:0] sync_d;
    logic       level_cur;
    logic       level_prev;

    assign sync_d = {sync_q[1:0], pwm_i};

    // NOTE: registered state is always updated with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign level_cur  = sync_q[1] ^ polarity_i;
    assign level_prev = sync_q[2] ^ polarity_i;

    assign rise_o = level_cur & ~level_prev;
    assign fall_o = ~level_cur & level_prev;

endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time of an external waveform
// on a prescaled timebase and reports each complete period with a strobe.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic [7:0]       prescale,
    input  logic             polarity,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_val,
    output logic [CNT_W-1:0] duty_val,
    output logic             valid,
    output logic             overflow,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic               rise;
    logic               fall;

    cap_state_e         state_q,  state_d;
    logic [PRESC_W-1:0] presc_q,  presc_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [CNT_W-1:0]   high_q,   high_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   duty_q,   duty_d;
    logic               valid_q,  valid_d;
    logic               ovf_q,    ovf_d;
    logic               busy_q,   busy_d;

    logic [3:0]         p_eff;
    logic [PRESC_W-1:0] presc_mask;
    logic               tick;
    logic               cnt_sat;
    logic [CNT_W-1:0]   sample;

    pwm_in_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .polarity_i (polarity),
        .pwm_i      (pwm_in),
        .rise_o     (rise),
        .fall_o     (fall)
    );

    // Masked compare lets a shrunken prescale recover at the next alignment.
    always_comb begin
        p_eff      = clamp_prescale(prescale);
        presc_mask = ~({PRESC_W{1'b1}} << p_eff);
        tick       = ((presc_q & presc_mask) == presc_mask);
        cnt_sat    = (cnt_q == CNT_MAX);
        sample     = cnt_sat ? CNT_MAX : cnt_q + CNT_W'(tick);
    end

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        presc_d  = tick ? '0 : presc_q + PRESC_W'(1);
        cnt_d    = (tick && !cnt_sat) ? cnt_q + CNT_W'(1) : cnt_q;
        high_d   = high_q;
        period_d = period_q;
        duty_d   = duty_q;
        valid_d  = 1'b0;
        ovf_d    = ovf_q;

        if (!en) begin
            state_d = ST_IDLE;
            presc_d = '0;
            cnt_d   = '0;
        end else if (clear) begin
            state_d  = ST_WAIT_RISE;
            presc_d  = '0;
            cnt_d    = '0;
            period_d = '0;
            duty_d   = '0;
            ovf_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT_RISE;
                end
                ST_WAIT_RISE: begin
                    if (rise) begin
                        state_d = ST_MEAS_HIGH;
                        cnt_d   = '0;
                        presc_d = '0;
                    end
                end
                ST_MEAS_HIGH: begin
                    if (cnt_sat) begin
                        ovf_d   = 1'b1;
                        state_d = ST_WAIT_RISE;
                    end else if (fall) begin
                        high_d  = sample;
                        state_d = ST_MEAS_LOW;
                    end
                end
                ST_MEAS_LOW: begin
                    if (cnt_sat) begin
                        ovf_d   = 1'b1;
                        state_d = ST_WAIT_RISE;
                    end else if (rise) begin
                        period_d = sample;
                        duty_d   = high_q;
                        valid_d  = 1'b1;
                        cnt_d    = '0;
                        presc_d  = '0;
                        state_d  = ST_MEAS_HIGH;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_MEAS_HIGH) || (state_d == ST_MEAS_LOW);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            cnt_q    <= '0;
            high_q   <= '0;
            period_q <= '0;
            duty_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            high_q   <= high_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
        end
    end

    assign period_val = period_q;
    assign duty_val   = duty_q;
    assign valid      = valid_q;
    assign overflow   = ovf_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: fixed vector table, hand-written corner
// sequences and randomized waveforms checked against a segment-arithmetic model.
module tb_pwm_capture;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             clear;
    logic [7:0]       prescale;
    logic             polarity;
    logic             pwm_in;
    logic [CNT_W-1:0] period_val;
    logic [CNT_W-1:0] duty_val;
    logic             valid;
    logic             overflow;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct { int period; int duty; int at; } meas_t;
    typedef struct { int period; int duty; } exp_t;
    typedef struct {
        int p; bit pol; int hi; int lo; int n; int exp_period; int exp_duty;
    } vec_t;

    meas_t got_q[$];
    exp_t  exp_q[$];
    int    seg_hi[16];
    int    seg_lo[16];
    int    seg_n;

    pwm_capture #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clear      (clear),
        .prescale   (prescale),
        .polarity   (polarity),
        .pwm_in     (pwm_in),
        .period_val (period_val),
        .duty_val   (duty_val),
        .valid      (valid),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid === 1'b1) got_q.push_back('{int'(period_val), int'(duty_val), cyc});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives seg_n periods (high seg_hi[i], low seg_lo[i]) after a fresh enable.
    task automatic run_wave(input int p, input bit pol, output int t_first);
        en = 1'b0; prescale = 8'(p); polarity = pol; pwm_in = 1'b0;
        step(4);
        got_q.delete();
        en = 1'b1;
        step(4);
        t_first = cyc;
        for (int i = 0; i < seg_n; i++) begin
            pwm_in = 1'b1; step(seg_hi[i]);
            pwm_in = 1'b0; step(seg_lo[i]);
        end
        step(8);
    endtask

    // Reference: every complete period between consecutive detected rises,
    // in clk cycles divided down by 2^p (floor), with the pin level inverted when pol=1.
    task automatic build_expected(input int p, input bit pol);
        int r[$];
        int f[$];
        int t;
        t = 0;
        exp_q.delete();
        for (int i = 0; i < seg_n; i++) begin
            r.push_back(t);
            f.push_back(t + seg_hi[i]);
            t += seg_hi[i] + seg_lo[i];
        end
        for (int i = 0; i < seg_n - 1; i++) begin
            if (!pol) exp_q.push_back('{(r[i+1] - r[i]) >> p, (f[i] - r[i]) >> p});
            else      exp_q.push_back('{(f[i+1] - f[i]) >> p, (r[i+1] - f[i]) >> p});
        end
    endtask

    task automatic compare_run(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_period%0d", tag, i), got_q[i].period, exp_q[i].period);
            check($sformatf("%s_duty%0d", tag, i), got_q[i].duty, exp_q[i].duty);
        end
    endtask

    initial begin
        vec_t tbl[4];
        int   t_first;
        int   t_drive;
        int   waited;
        int   p;
        bit   pol;

        tbl[0] = '{0, 1'b0, 3, 7,  4, 10, 3};
        tbl[1] = '{2, 1'b0, 8, 32, 3, 10, 2};
        tbl[2] = '{0, 1'b1, 3, 7,  4, 10, 7};
        tbl[3] = '{1, 1'b0, 5, 6,  4, 5,  2};

        rst = 1'b1; en = 1'b0; clear = 1'b0; prescale = '0; polarity = 1'b0; pwm_in = 1'b0;
        step(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_period", period_val, 0);
        check("rst_duty", duty_val, 0);
        check("rst_valid", valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);

        // Table-driven steady waveforms.
        for (int v = 0; v < 4; v++) begin
            seg_n = tbl[v].n;
            for (int i = 0; i < seg_n; i++) begin
                seg_hi[i] = tbl[v].hi;
                seg_lo[i] = tbl[v].lo;
            end
            exp_q.delete();
            for (int i = 0; i < tbl[v].n - 1; i++) exp_q.push_back('{tbl[v].exp_period, tbl[v].exp_duty});
            run_wave(tbl[v].p, tbl[v].pol, t_first);
            compare_run($sformatf("tbl%0d", v));
            check($sformatf("tbl%0d_busy", v), busy, 1);
            if (v == 0 && got_q.size() >= 2) begin
                check("tbl0_latency", got_q[0].at - (t_first + 10), 3);
                check("tbl0_spacing", got_q[1].at - got_q[0].at, 10);
            end
        end

        // en dropped in MEAS_LOW: aborted period never reported, outputs held.
        en = 1'b0; prescale = '0; polarity = 1'b0; pwm_in = 1'b0;
        step(4);
        got_q.delete();
        en = 1'b1; step(4);
        pwm_in = 1'b1; step(3);
        pwm_in = 1'b0; step(7);
        check("endrop_busy_meas_low", busy, 1);
        en = 1'b0; step(3);
        check("endrop_hold_period", period_val, 5);
        check("endrop_hold_duty", duty_val, 2);
        check("endrop_busy_idle", busy, 0);
        en = 1'b1; step(2);
        pwm_in = 1'b1; step(3);
        pwm_in = 1'b0; step(7);
        pwm_in = 1'b1; step(3);
        pwm_in = 1'b0; step(15);
        exp_q.delete();
        exp_q.push_back('{10, 3});
        compare_run("endrop");

        // clear coincident with a rise detect: edge discarded, outputs zeroed.
        got_q.delete();
        pwm_in = 1'b1; step(2);
        clear = 1'b1; step(1);
        clear = 1'b0;
        check("clr_busy", busy, 0);
        check("clr_period", period_val, 0);
        check("clr_duty", duty_val, 0);
        check("clr_valid", valid, 0);
        step(1);
        pwm_in = 1'b0; step(7);
        pwm_in = 1'b1; step(3);
        pwm_in = 1'b0; step(7);
        pwm_in = 1'b1; step(3);
        pwm_in = 1'b0; step(15);
        exp_q.delete();
        exp_q.push_back('{10, 3});
        compare_run("clr");

        // Randomized waveforms against the segment model.
        for (int it = 0; it < 8; it++) begin
            seg_n = $urandom_range(3, 6);
            for (int i = 0; i < seg_n; i++) begin
                seg_hi[i] = $urandom_range(2, 13);
                seg_lo[i] = $urandom_range(2, 13);
            end
            p   = $urandom_range(0, 3);
            pol = 1'($urandom_range(0, 1));
            build_expected(p, pol);
            run_wave(p, pol, t_first);
            compare_run($sformatf("rnd%0d", it));
        end

        // Pin stuck high: a stretched period is reported, then the counter saturates.
        seg_n = 3;
        for (int i = 0; i < seg_n; i++) begin
            seg_hi[i] = 3;
            seg_lo[i] = 7;
        end
        run_wave(0, 1'b0, t_first);
        got_q.delete();
        pwm_in = 1'b1;
        t_drive = cyc;
        step(6);
        exp_q.delete();
        exp_q.push_back('{18, 3});
        compare_run("stretch");
        got_q.delete();
        waited = -1;
        for (int k = 0; k < 70000; k++) begin
            @(negedge clk);
            if (overflow === 1'b1) begin
                waited = cyc - t_drive;
                break;
            end
        end
        check("ovf_set", overflow, 1);
        check("ovf_window", (waited >= 65530 && waited <= 65550) ? 1 : 0, 1);
        check("ovf_busy", busy, 0);
        check("ovf_no_valid", got_q.size(), 0);
        check("ovf_hold_period", period_val, 18);
        check("ovf_hold_duty", duty_val, 3);
        step(1);
        clear = 1'b1; step(1);
        clear = 1'b0;
        @(negedge clk);
        check("ovf_clr_overflow", overflow, 0);
        check("ovf_clr_period", period_val, 0);
        check("ovf_clr_duty", duty_val, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
